// File: rtl/fc_weight_rom_streamer.sv
// fc_weight_rom_streamer
//   Address sequencer plus elastic output buffer between a ROM holding FC-layer
//   weights and the linear-layer datapath. Reads are only issued when a FIFO
//   slot is guaranteed for the returning word (credit scheme), so the ROM never
//   needs to be stalled and backpressure never drops or repeats a beat.
//
//   Optional feature macro: WEIGHT_STREAM_REPEAT_EN
//     defined   : free-running stream, address wraps forever, start ignored
//     undefined : one full tensor per start pulse
//
// Ports
//   clk            clock
//   rst            synchronous reset, active-low
//   start          begin one tensor pass (ignored unless idle)
//   busy           high while issuing or draining
//   mem_addr       ROM read address
//   mem_ce         ROM clock enable (constant 1)
//   mem_q          ROM read data, READ_LATENCY cycles after mem_addr
//   data_out       beat payload, element j at [DATA_WIDTH*j +: DATA_WIDTH]
//   data_out_valid beat available
//   data_out_ready consumer accepts beat
//   data_out_last  beat carries the final tensor address

module fc_weight_rom_streamer #(
  parameter int DATA_WIDTH   = 16,
  parameter int PARALLELISM  = 1,
  parameter int OUT_DEPTH    = 32,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int ADDR_WIDTH   = $clog2(OUT_DEPTH + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  output logic                              busy,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic                              mem_ce,
  input  logic [DATA_WIDTH*PARALLELISM-1:0] mem_q,
  output logic [DATA_WIDTH*PARALLELISM-1:0] data_out,
  output logic                              data_out_valid,
  input  logic                              data_out_ready,
  output logic                              data_out_last
);

  localparam int WORD_W = DATA_WIDTH * PARALLELISM;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(OUT_DEPTH - 1);
  localparam logic [CNT_W:0]        FIFO_CAP  = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                  state, state_next;
  logic                    issue, issue_last, push, pop;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [READ_LATENCY-1:0] dl_vld, dl_lst;
  logic [CNT_W-1:0]        fifo_count, inflight;
  logic [CNT_W:0]          occupancy;
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [WORD_W-1:0]       fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   fifo_last;

`ifdef WEIGHT_STREAM_REPEAT_EN
  logic unused_start;
  assign unused_start = start;
`endif

  // Slots already spoken for: words sitting in the FIFO plus reads still in
  // the ROM pipeline. A read may only go out if this leaves room for it.
  assign occupancy  = {1'b0, fifo_count} + {1'b0, inflight};
  assign issue_last = (addr_q == LAST_ADDR);
  assign push       = dl_vld[READ_LATENCY-1];

  assign mem_addr       = addr_q;
  assign mem_ce         = 1'b1;
  assign data_out_valid = (fifo_count != '0);
  assign pop            = data_out_valid && data_out_ready;
  assign data_out       = data_out_valid ? fifo_data[rd_ptr] : '0;
  assign data_out_last  = data_out_valid && fifo_last[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
`ifdef WEIGHT_STREAM_REPEAT_EN
        state_next = ISSUE;
`else
        if (start) state_next = ISSUE;
`endif
      end
      ISSUE: begin
        if (occupancy < FIFO_CAP) begin
          issue = 1'b1;
`ifndef WEIGHT_STREAM_REPEAT_EN
          if (issue_last) state_next = DRAIN;
`endif
        end
      end
      DRAIN: begin
        // FIFO only ever holds the current pass, so the tagged beat is final
        if (pop && data_out_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Address counter and the ROM-latency shadow pipeline of {issued, is_last}
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q   <= '0;
      dl_vld   <= '0;
      dl_lst   <= '0;
      inflight <= '0;
    end else begin
      if (issue) addr_q <= issue_last ? '0 : addr_q + ADDR_WIDTH'(1);
      dl_vld[0] <= issue;
      dl_lst[0] <= issue && issue_last;
      for (int i = 1; i < READ_LATENCY; i++) begin
        dl_vld[i] <= dl_vld[i-1];
        dl_lst[i] <= dl_lst[i-1];
      end
      case ({issue, push})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // FIFO bookkeeping; pointers wrap naturally since FIFO_DEPTH is a power of 2
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset: contents are only visible while count is nonzero
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= mem_q;
      fifo_last[wr_ptr] <= dl_lst[READ_LATENCY-1];
    end
  end

endmodule

// File: tb/tb_fc_weight_rom_streamer.sv
// Testbench for fc_weight_rom_streamer: behavioural ROM (ROM[i]=i, latency 2),
// scoreboard queue filled by a tensor-level model, monitor popping on handshake.

module tb_fc_weight_rom_streamer;

  localparam int DW    = 16;
  localparam int DEPTH = 32;
  localparam int AW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic [AW-1:0] mem_addr;
  logic          mem_ce;
  logic [DW-1:0] mem_q;
  logic [DW-1:0] data_out;
  logic          data_out_valid;
  logic          data_out_ready;
  logic          data_out_last;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t   sb[$];
  int      tests = 0;
  int      failed = 0;
  int      pop_count = 0;
  int      rep_idx = 0;
  bit      model_busy = 0;
  bit      pending_idle = 0;
  bit      mon_en = 0;
  logic [AW-1:0] rom_p1;

  always #5 clk = ~clk;

  fc_weight_rom_streamer dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .mem_addr(mem_addr), .mem_ce(mem_ce), .mem_q(mem_q),
    .data_out(data_out), .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready), .data_out_last(data_out_last)
  );

  // ROM with two-cycle read latency, contents ROM[i] = i
  always @(posedge clk) begin
    if (mem_ce) begin
      rom_p1 <= mem_addr;
      mem_q  <= DW'(rom_p1);
    end
  end

  // Tensor-level model: an accepted start means the next DEPTH beats carry
  // addresses 0..DEPTH-1 with last on the final one
  always @(posedge clk) begin
    if (!rst) begin
      sb.delete();
      model_busy   = 0;
      pending_idle = 0;
      rep_idx      = 0;
    end else begin
`ifdef WEIGHT_STREAM_REPEAT_EN
      model_busy = 1;
      while (sb.size() < 8) begin
        sb.push_back('{DW'(rep_idx), rep_idx == DEPTH - 1});
        rep_idx = (rep_idx + 1) % DEPTH;
      end
`else
      if (start && !model_busy) begin
        model_busy = 1;
        for (int i = 0; i < DEPTH; i++) sb.push_back('{DW'(i), i == DEPTH - 1});
      end
      if (pending_idle) begin
        model_busy   = 0;
        pending_idle = 0;
      end
`endif
    end
  end

  // Monitor: every presented beat must match the scoreboard head (this also
  // proves payload stability while stalled); pop on handshake
  always @(negedge clk) begin
    if (mon_en) begin
      tests++;
      if (busy !== model_busy) begin
        failed++;
        $display("[TB] FAIL busy: got %0b expected %0b at %0t", busy, model_busy, $time);
      end
      if (data_out_valid === 1'b1) begin
        tests++;
        if (sb.size() == 0) begin
          failed++;
          $display("[TB] FAIL unexpected_beat: got data %0d last %0b, expected no beat at %0t",
                   data_out, data_out_last, $time);
        end else begin
          if (data_out !== sb[0].data || data_out_last !== sb[0].last) begin
            failed++;
            $display("[TB] FAIL beat: got data %0d last %0b expected data %0d last %0b at %0t",
                     data_out, data_out_last, sb[0].data, sb[0].last, $time);
          end
          if (data_out_ready) begin
            if (sb[0].last) pending_idle = 1;
            void'(sb.pop_front());
            pop_count++;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic r);
    start          = s;
    data_out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset();
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 0);
    checkOutput("rst_mem_ce", 32'(mem_ce), 1);
    checkOutput("rst_valid", 32'(data_out_valid), 0);
    checkOutput("rst_last", 32'(data_out_last), 0);
    checkOutput("rst_data", 32'(data_out), 0);
  endtask

  task automatic waitIdle(input string name, input int budget);
    int n = 0;
    while ((model_busy || sb.size() != 0 || pending_idle) && n < budget) begin
      applyStimulus(0, 1);
      n++;
    end
    checkOutput(name, 32'(n < budget), 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cyc;
    rst = 1'b0;
    start = 1'b0;
    data_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    mon_en = 1;
    checkReset();

`ifdef WEIGHT_STREAM_REPEAT_EN
    pop_count = 0;
    for (int k = 0; k < 100; k++) applyStimulus($urandom_range(0, 4) == 0, 1);
    checkOutput("repeat_beats_ge90", 32'(pop_count >= 90), 1);
    for (int k = 0; k < 100; k++) applyStimulus($urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0);
`else
    // Full-rate pass: latency and busy timing
    pop_count = 0;
    applyStimulus(1, 1);
    cyc = 1;
    while (!data_out_valid && cyc < 20) begin
      applyStimulus(0, 1);
      cyc++;
    end
    checkOutput("first_valid_latency", 32'(cyc), 4);
    while (busy && cyc < 80) begin
      applyStimulus(0, 1);
      cyc++;
    end
    checkOutput("busy_drop_cycle", 32'(cyc), 36);
    checkOutput("pass_beats", 32'(pop_count), 32);
    checkOutput("addr_wrapped", 32'(mem_addr), 0);

    // Consumer stalled after start: credits cap outstanding reads
    pop_count = 0;
    applyStimulus(1, 0);
    repeat (19) applyStimulus(0, 0);
    checkOutput("stall_reads_issued", 32'(mem_addr), 4);
    checkOutput("stall_valid", 32'(data_out_valid), 1);
    waitIdle("stall_drain_done", 200);
    checkOutput("stall_beats", 32'(pop_count), 32);

    // Ready toggling with redundant start pulses while busy
    pop_count = 0;
    applyStimulus(1, 0);
    for (int k = 1; k < 100 && (model_busy || sb.size() != 0); k++)
      applyStimulus(k == 8 || k == 60, k % 2 == 1);
    waitIdle("toggle_drain_done", 100);
    checkOutput("toggle_beats", 32'(pop_count), 32);

    // Reset in the middle of a pass, then a fresh pass from address 0
    pop_count = 0;
    applyStimulus(1, 1);
    cyc = 0;
    while (pop_count < 10 && cyc < 50) begin
      applyStimulus(0, 1);
      cyc++;
    end
    rst = 1'b0;
    applyStimulus(0, 1);
    rst = 1'b1;
    checkReset();
    repeat (6) applyStimulus(0, 1);
    pop_count = 0;
    applyStimulus(1, 1);
    waitIdle("post_reset_drain_done", 100);
    checkOutput("post_reset_beats", 32'(pop_count), 32);

    // Randomized start/ready traffic
    for (int k = 0; k < 400; k++)
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
    waitIdle("random_drain_done", 300);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
